// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB slice first,
// with a registered carry between slices and valid/ready on both sides.
module chunked_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int KW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NCHUNK - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [KW-1:0]    k_q, k_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [CHUNK-1:0] sa, sb, ss;
    logic             c_top, c_msb, c;
    int               base;

    // Bit-level ripple over one slice; c_msb is the carry into the slice's top bit.
    always_comb begin
        base  = int'(k_q) * CHUNK;
        sa    = a_q[base +: CHUNK];
        sb    = b_q[base +: CHUNK];
        ss    = '0;
        c     = carry_q;
        c_msb = carry_q;
        for (int i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) c_msb = c;
            ss[i] = sa[i] ^ sb[i] ^ c;
            c     = (sa[i] & sb[i]) | (c & (sa[i] ^ sb[i]));
        end
        c_top = c;
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        k_d     = k_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = sub ? ~b : b;
                    carry_d = cin ^ sub;
                    k_d     = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                sum_d[base +: CHUNK] = ss;
                carry_d = c_top;
                if (k_q == KLAST) begin
                    cout_d  = c_top;
                    ovf_d   = c_msb ^ c_top;
                    state_d = DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            k_q     <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            k_q     <= k_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: doc/chunked_addsub.md
Name: chunked_addsub

Overview:
- Parametrised multi-cycle adder/subtractor; successor to the team's fixed 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands CHUNK bits per clock, LSB chunk first, with a registered carry between chunks.
- Uses valid/ready handshakes on input and output, so it can sit between switch/register front-ends and HEX/LED display logic, or inside wider datapaths without a long combinational carry chain.

Parameters:
- WIDTH, 16, operand and result width in bits.
- CHUNK, 4, bits added per cycle. WIDTH mod CHUNK must be 0. NCHUNK = WIDTH/CHUNK.

Ports:
- CLOCK_50  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- in_valid  in  1  operands and mode are valid this cycle.
- in_ready  out  1  block can accept an operation; equals (state==IDLE).
- a  in  WIDTH  operand A, unsigned or two's complement.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in for add; borrow-in for subtract.
- sub  in  1  0: a+b+cin. 1: a-b-cin.
- sum  out  WIDTH  result, registered.
- cout  out  1  raw carry out of MSB. For subtract, 1 means no borrow.
- overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- out_valid  out  1  sum/cout/overflow are valid.
- out_ready  in  1  consumer accepts the result.

Behaviour:
- Reset (async, any state):
  - state=IDLE; sum=0, cout=0, overflow=0, out_valid=0; internal operand, carry and chunk counter cleared.
  - in_ready=1 while in reset and after release.
  - Any operation in progress is discarded with no output.
- IDLE:
  - in_ready=1, out_valid=0.
  - On a rising edge with in_valid=1, latch A=a and B = sub ? ~b : b. Set carry = cin ^ sub, counter k=0, go to BUSY.
  - With in_valid=0, stay in IDLE.
- BUSY:
  - in_ready=0; in_valid is ignored.
  - Each edge: {c, s} = A[k] + B[k] + carry on CHUNK-bit slice k. Write s to sum slice k; carry = c; k = k+1.
  - On the final slice (k=NCHUNK-1):
    - cout = carry out of bit WIDTH-1.
    - overflow = carry into bit WIDTH-1 XOR cout. The internal bit-level carry of the top slice is needed for this.
    - Go to DONE.
  - Sum slices not yet computed hold stale or partial values; they are don't-care while out_valid=0.
- DONE:
  - out_valid=1; in_ready=0. sum, cout and overflow are held stable.
  - On an edge with out_ready=1: out_valid=0, go to IDLE. The result registers keep their values.
  - With out_ready=0: hold indefinitely.
- Latency:
  - Operation accepted at edge t; out_valid rises at edge t+NCHUNK.
  - Earliest next acceptance is the edge after the output handshake edge.
  - Throughput is one operation per NCHUNK+2 cycles when out_ready is held high.
- Boundaries:
  - CHUNK==WIDTH: one BUSY cycle, out_valid at t+1.
  - Arithmetic wraps modulo 2^WIDTH; no saturation.
  - The counter wraps only via the IDLE reload; it never exceeds NCHUNK-1.
  - in_valid and out_ready asserted together in DONE: only out_ready acts.
  - Operands changing after acceptance have no effect.
- Sign interpretation of inputs is the consumer's choice. cout is the unsigned flag; overflow is the signed flag.

Test Plan (WIDTH=16, CHUNK=4 unless stated):
- a=0x00FF, b=0x0001, cin=0, sub=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0x0100, cout=0, overflow=0.
- a=0xFFFF, b=0x0001, add -> sum=0x0000, cout=1, overflow=0. a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, overflow=1. a=0x0003, b=0x0004, cin=1 -> sum=0x0008.
- Subtract: a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0, overflow=0. a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, overflow=1. a=0x0005, b=0x0002, sub=1, cin=1 -> sum=0x0002, cout=1.
- Backpressure: out_ready=0 for 3 cycles after out_valid -> sum/cout/overflow/out_valid unchanged. in_valid held high during BUSY and DONE is not accepted (in_ready=0). A new operation is accepted on the first edge after the handshake edge.
- Reset in the 2nd BUSY cycle -> sum=0, cout=0, overflow=0, out_valid=0 immediately (asynchronous). in_ready=1. After release, a fresh 0x1234+0x1111 gives 0x2345 after 4 cycles.
- Parameter sweep: CHUNK=16 -> 1-cycle latency with the same results as above. WIDTH=8, CHUNK=2: 0x7F+0x01 -> sum=0x80, overflow=1, latency 4. Randomised 1000 operations vs a behavioural model.
